// File: rtl/mae_share_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : mae_share_ctrl
//  Purpose  : Shares one MAE multiplier (18x18 signed in, 40-bit P out)
//             between NREQ fabric requesters. A round-robin arbiter issues
//             at most one operand pair per cycle; a tag pipeline follows
//             each operation through the MAE and returns its P result,
//             flagged to the requester that issued it.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    NREQ : number of requesters (2..8)
//    LAT  : MAE pipeline depth in cycles (0..4); must match the MAE
//           register configuration (in+out regs = 2, one side = 1, none = 0)
//    IDW  : requester ID width, 2**IDW >= NREQ
//  Ports
//    clk_i        clock, shared with the MAE
//    srst_n_i     synchronous active-low reset
//    hold_i       blocks new grants; in-flight operations still drain
//    req_valid_i  per-requester operand valid
//    req_a_i      packed A operands, requester i at [18i+17:18i]
//    req_b_i      packed B operands, same packing
//    req_clr_i    accumulator clear (accumulator build only)
//    req_ready_o  one-hot grant, combinational from req_valid_i
//    mae_a_o      A operand to the MAE (registered)
//    mae_b_o      B operand to the MAE (registered)
//    mae_en_o     MAE A_EN/B_EN/P_EN, held high once out of reset
//    mae_p_i      MAE P output
//    res_valid_o  one-hot single-cycle result strobe, no backpressure
//    res_data_o   result value, holds when no result is returned
//    res_id_o     owner of res_data_o
//    inflight_o   operations issued and not yet returned (0..LAT)
//  Build option
//    MAE_SHARE_ACC_EN : when defined, one 40-bit accumulator per requester;
//                       res_data_o returns the updated accumulator instead
//                       of the raw product.
// ============================================================================
module mae_share_ctrl #(
    parameter int NREQ = 4,
    parameter int LAT  = 2,
    parameter int IDW  = 3
) (
    input  logic              clk_i,
    input  logic              srst_n_i,
    input  logic              hold_i,
    input  logic [NREQ-1:0]   req_valid_i,
    input  logic [NREQ*18-1:0] req_a_i,
    input  logic [NREQ*18-1:0] req_b_i,
    input  logic [NREQ-1:0]   req_clr_i,
    output logic [NREQ-1:0]   req_ready_o,
    output logic [17:0]       mae_a_o,
    output logic [17:0]       mae_b_o,
    output logic              mae_en_o,
    input  logic [39:0]       mae_p_i,
    output logic [NREQ-1:0]   res_valid_o,
    output logic [39:0]       res_data_o,
    output logic [IDW-1:0]    res_id_o,
    output logic [2:0]        inflight_o
);

    localparam int c_DW = 18;
    localparam int c_PW = 40;

    // ------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------
    logic [IDW-1:0]  ptr_q;
    logic [IDW-1:0]  ptr_d;
    logic            w_gnt_found;
    logic [IDW-1:0]  w_gnt_id;
    logic            w_issue;
    logic [c_DW-1:0] w_sel_a;
    logic [c_DW-1:0] w_sel_b;
    logic            w_sel_clr;

    logic [c_DW-1:0] mae_a_q;
    logic [c_DW-1:0] mae_b_q;
    logic            mae_en_q;

    // Stage 0 is aligned with mae_a_q/mae_b_q, stage LAT with mae_p_i.
    logic            tag_v_q   [LAT+1];
    logic [IDW-1:0]  tag_id_q  [LAT+1];
    logic            tag_clr_q [LAT+1];

    logic            w_ret;
    logic [IDW-1:0]  w_ret_id;
    logic            w_ret_clr;
    logic [c_PW-1:0] w_ret_data;

    logic [NREQ-1:0] res_valid_q;
    logic [NREQ-1:0] res_valid_d;
    logic [c_PW-1:0] res_data_q;
    logic [IDW-1:0]  res_id_q;

    logic [2:0]      inflight_q;
    logic            w_cnt_inc;
    logic            w_cnt_dec;

    // ------------------------------------------------------------------
    // Round-robin arbiter: scan from ptr_q, wrapping modulo NREQ.
    // ------------------------------------------------------------------
    always_comb begin
        w_gnt_found = 1'b0;
        w_gnt_id    = '0;
        for (int k = 0; k < NREQ; k++) begin
            for (int j = 0; j < NREQ; j++) begin
                if (!w_gnt_found && req_valid_i[j] &&
                    (j == ((int'(ptr_q) + k) % NREQ))) begin
                    w_gnt_found = 1'b1;
                    w_gnt_id    = IDW'(j);
                end
            end
        end
    end

    assign w_issue = srst_n_i & ~hold_i & w_gnt_found;
    assign ptr_d   = (w_gnt_id == IDW'(NREQ - 1)) ? '0 : w_gnt_id + IDW'(1);

    always_comb begin
        req_ready_o = '0;
        w_sel_a     = '0;
        w_sel_b     = '0;
        w_sel_clr   = 1'b0;
        for (int j = 0; j < NREQ; j++) begin
            if (w_gnt_id == IDW'(j)) begin
                req_ready_o[j] = w_issue;
                w_sel_a        = req_a_i[j*c_DW +: c_DW];
                w_sel_b        = req_b_i[j*c_DW +: c_DW];
                w_sel_clr      = req_clr_i[j];
            end
        end
    end

    // ------------------------------------------------------------------
    // Issue registers; idle cycles keep the last operands on the MAE.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (!srst_n_i) begin
            ptr_q    <= '0;
            mae_a_q  <= '0;
            mae_b_q  <= '0;
            mae_en_q <= 1'b0;
        end else begin
            mae_en_q <= 1'b1;
            if (w_issue) begin
                ptr_q   <= ptr_d;
                mae_a_q <= w_sel_a;
                mae_b_q <= w_sel_b;
            end
        end
    end

    // ------------------------------------------------------------------
    // Tag pipeline
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (!srst_n_i) begin
            for (int s = 0; s <= LAT; s++) begin
                tag_v_q[s]   <= 1'b0;
                tag_id_q[s]  <= '0;
                tag_clr_q[s] <= 1'b0;
            end
        end else begin
            tag_v_q[0]   <= w_issue;
            tag_id_q[0]  <= w_gnt_id;
            tag_clr_q[0] <= w_sel_clr;
            for (int s = 1; s <= LAT; s++) begin
                tag_v_q[s]   <= tag_v_q[s-1];
                tag_id_q[s]  <= tag_id_q[s-1];
                tag_clr_q[s] <= tag_clr_q[s-1];
            end
        end
    end

    assign w_ret     = tag_v_q[LAT];
    assign w_ret_id  = tag_id_q[LAT];
    assign w_ret_clr = tag_clr_q[LAT];

    // ------------------------------------------------------------------
    // In-flight count: tags in stages 0..LAT-1. The tag in stage LAT is
    // returning this cycle and no longer counts.
    // ------------------------------------------------------------------
    generate
        if (LAT == 0) begin : g_lat0
            assign w_cnt_inc = 1'b0;
            assign w_cnt_dec = 1'b0;
        end else begin : g_latn
            assign w_cnt_inc = w_issue;
            assign w_cnt_dec = tag_v_q[LAT-1];
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        if (!srst_n_i) begin
            inflight_q <= '0;
        end else if (w_cnt_inc && !w_cnt_dec) begin
            inflight_q <= inflight_q + 3'd1;
        end else if (!w_cnt_inc && w_cnt_dec) begin
            inflight_q <= inflight_q - 3'd1;
        end
    end

    // ------------------------------------------------------------------
    // Result value: accumulator or raw product
    // ------------------------------------------------------------------
`ifdef MAE_SHARE_ACC_EN
    logic [c_PW-1:0] acc_q [NREQ];
    logic [c_PW-1:0] w_acc_base;

    always_comb begin
        w_acc_base = '0;
        for (int j = 0; j < NREQ; j++) begin
            if ((w_ret_id == IDW'(j)) && !w_ret_clr) begin
                w_acc_base = acc_q[j];
            end
        end
    end

    // 40-bit add wraps modulo 2**40.
    assign w_ret_data = w_acc_base + mae_p_i;

    always_ff @(posedge clk_i) begin
        if (!srst_n_i) begin
            for (int j = 0; j < NREQ; j++) begin
                acc_q[j] <= '0;
            end
        end else if (w_ret) begin
            for (int j = 0; j < NREQ; j++) begin
                if (w_ret_id == IDW'(j)) begin
                    acc_q[j] <= w_ret_data;
                end
            end
        end
    end
`else
    logic w_unused_clr;
    assign w_unused_clr = w_ret_clr;
    assign w_ret_data   = mae_p_i;
`endif

    // ------------------------------------------------------------------
    // Result registers
    // ------------------------------------------------------------------
    always_comb begin
        res_valid_d = '0;
        for (int j = 0; j < NREQ; j++) begin
            if (w_ret_id == IDW'(j)) begin
                res_valid_d[j] = w_ret;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!srst_n_i) begin
            res_valid_q <= '0;
            res_data_q  <= '0;
            res_id_q    <= '0;
        end else begin
            res_valid_q <= res_valid_d;
            if (w_ret) begin
                res_data_q <= w_ret_data;
                res_id_q   <= w_ret_id;
            end
        end
    end

    assign mae_a_o     = mae_a_q;
    assign mae_b_o     = mae_b_q;
    assign mae_en_o    = mae_en_q;
    assign res_valid_o = res_valid_q;
    assign res_data_o  = res_data_q;
    assign res_id_o    = res_id_q;
    assign inflight_o  = inflight_q;

endmodule
`default_nettype wire
